// File: rtl/hc595_pkg.sv
// Shared types and default sizing for the 74HC595 chain driver.
package hc595_pkg;

    localparam int HC595_DATA_W  = 8;
    localparam int HC595_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SH_LO = 3'd1,
        SH_HI = 3'd2,
        LT_HI = 3'd3,
        LT_LO = 3'd4
    } hc595_state_e;

endpackage

// File: rtl/hc595_tick_div.sv
// Phase divider for the 595 driver: a down-counter that reloads on restart
// and on terminal count, producing a one-cycle tick every CLK_DIV cycles.
// tick_next_o predicts the tick of the following cycle so that outputs
// which must coincide with the last cycle of a phase can be registered.
module hc595_tick_div
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = HC595_CLK_DIV
) (
    input  logic CLK,
    input  logic MR,
    input  logic restart_i,
    output logic tick_o,
    output logic tick_next_o
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on restart or terminal count, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o      = (cnt_q == '0);
    assign tick_next_o = (cnt_d == '0);

endmodule

// File: rtl/hc595_driver.sv
// Serial driver for a cascaded 74HC595 chain: accepts a parallel word on a
// valid/ready handshake, shifts it out MSB first on DS/SHCP, then pulses
// STCP to latch it.
// Build option HC595_OE_BLANK_EN: hold OE_N high from reset until the first
// completed latch so power-up garbage on the 595 outputs stays blanked.
//
//   state | meaning
//   IDLE  | waiting for a word, in_ready=1
//   SH_LO | SHCP low, DS presents current MSB of the shadow register
//   SH_HI | SHCP high, DS held; shift shadow on exit
//   LT_HI | STCP high, storage register loads
//   LT_LO | STCP low, done in its last cycle
module hc595_driver
    import hc595_pkg::*;
#(
    parameter int DATA_W  = HC595_DATA_W,
    parameter int CLK_DIV = HC595_CLK_DIV
) (
    input  logic              CLK,
    input  logic              MR,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              done,
    output logic              DS,
    output logic              SHCP,
    output logic              STCP,
    output logic              OE_N
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    hc595_state_e      state_q, state_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              ds_q, ds_d;
    logic              shcp_q, shcp_d;
    logic              stcp_q, stcp_d;
    logic              restart;
    logic              tick;
    logic              tick_next;

    hc595_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .CLK         (CLK),
        .MR          (MR),
        .restart_i   (restart),
        .tick_o      (tick),
        .tick_next_o (tick_next)
    );

    // Next-state logic; pin values are derived from the next state so every
    // output comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        bit_cnt_d = bit_cnt_q;
        restart   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    shadow_d  = in_data;
                    bit_cnt_d = '0;
                    state_d   = SH_LO;
                    restart   = 1'b1;
                end
            end
            SH_LO: begin
                if (tick) state_d = SH_HI;
            end
            SH_HI: begin
                if (tick) begin
                    shadow_d  = shadow_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? LT_HI : SH_LO;
                end
            end
            LT_HI: begin
                if (tick) state_d = LT_LO;
            end
            LT_LO: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        shcp_d  = (state_d == SH_HI);
        stcp_d  = (state_d == LT_HI);
        // DS only moves on entry to SH_LO, i.e. while SHCP is low.
        ds_d    = (state_d == SH_LO) ? shadow_d[DATA_W-1] : ds_q;
        done_d  = (state_d == LT_LO) && tick_next;
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            ds_q      <= 1'b0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            ds_q      <= ds_d;
            shcp_q    <= shcp_d;
            stcp_q    <= stcp_d;
        end
    end

`ifdef HC595_OE_BLANK_EN
    logic oe_n_q;

    // Blank outputs until the first word has been latched since reset.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            oe_n_q <= 1'b1;
        end else if (done_d) begin
            oe_n_q <= 1'b0;
        end
    end

    assign OE_N = oe_n_q;
`else
    assign OE_N = 1'b0;
`endif

    assign in_ready = ready_q;
    assign done     = done_q;
    assign DS       = ds_q;
    assign SHCP     = shcp_q;
    assign STCP     = stcp_q;

endmodule
